// File: rtl/pipe_stage_reg_if.sv
// Stage-register bus: stall/flush control, payload in/out and perf counters.
// The master drives the upstream side; the slave is the register itself.
interface pipe_stage_reg_if #(
  parameter int DATA_W  = 64,
  parameter int STALL_W = 6,
  parameter int CNT_W   = 16
) ();
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [DATA_W-1:0]  in_data;
  logic               in_valid;
  logic               cnt_clr;
  logic [DATA_W-1:0]  out_data;
  logic               out_valid;
  logic [CNT_W-1:0]   bubble_cnt;
  logic [CNT_W-1:0]   hold_cnt;
  logic [CNT_W-1:0]   flush_cnt;

  modport master (
    output stall, flush, in_data, in_valid, cnt_clr,
    input  out_data, out_valid,
    input  bubble_cnt, hold_cnt, flush_cnt
  );

  modport slave (
    input  stall, flush, in_data, in_valid, cnt_clr,
    output out_data, out_valid,
    output bubble_cnt, hold_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with hold/bubble/flush control
// and saturating bubble/hold/flush event counters.
module pipe_stage_reg #(
  parameter int               DATA_W     = 64,
  parameter int               STALL_W    = 6,
  parameter int               STAGE      = 2,
  parameter logic [DATA_W-1:0] NOP_VAL   = '0,
  parameter bit               FLUSH_KEEP = 1'b0,
  parameter int               CNT_W      = 16
) (
  input logic            clk,
  input logic            rst,
  pipe_stage_reg_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              s;
  logic              d;
  logic              ev_flush;
  logic              ev_bub;
  logic              ev_hold;
  logic              ev_adv;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic [CNT_W-1:0]  bub_q;
  logic [CNT_W-1:0]  hold_q;
  logic [CNT_W-1:0]  flush_q;

  assign s = bus.stall[STAGE];
  assign d = bus.stall[STAGE+1];

  // One-hot event decode; flush dominates any stall state.
  // s=0,d=1 is not legal upstream but simply advances here.
  assign ev_flush = bus.flush;
  assign ev_bub   = !bus.flush && s && !d;
  assign ev_hold  = !bus.flush && s && d;
  assign ev_adv   = !bus.flush && !s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= NOP_VAL;
      valid_q <= 1'b0;
    end else begin
      unique case (1'b1)
        ev_flush: begin
          valid_q <= 1'b0;
          if (!FLUSH_KEEP) data_q <= NOP_VAL;
        end
        ev_bub: begin
          data_q  <= NOP_VAL;
          valid_q <= 1'b0;
        end
        ev_hold: begin
          data_q  <= data_q;
          valid_q <= valid_q;
        end
        ev_adv: begin
          data_q  <= bus.in_data;
          valid_q <= bus.in_valid;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bub_q   <= '0;
      hold_q  <= '0;
      flush_q <= '0;
    end else if (bus.cnt_clr) begin
      bub_q   <= '0;
      hold_q  <= '0;
      flush_q <= '0;
    end else begin
      if (ev_bub && bub_q != CNT_MAX)
        bub_q <= bub_q + 1'b1;
      if (ev_hold && hold_q != CNT_MAX)
        hold_q <= hold_q + 1'b1;
      if (ev_flush && flush_q != CNT_MAX)
        flush_q <= flush_q + 1'b1;
    end
  end

  assign bus.out_data   = data_q;
  assign bus.out_valid  = valid_q;
  assign bus.bubble_cnt = bub_q;
  assign bus.hold_cnt   = hold_q;
  assign bus.flush_cnt  = flush_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: four parameter variants driven in lockstep
// and compared against an event-level reference model.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        cnt_clr = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(64, 6, 16) b0 ();
  pipe_stage_reg_if #(64, 6, 16) b1 ();
  pipe_stage_reg_if #(64, 6, 4)  b2 ();
  pipe_stage_reg_if #(8, 6, 16)  b3 ();

  assign b0.stall = stall;
  assign b1.stall = stall;
  assign b2.stall = stall;
  assign b3.stall = stall;
  assign b0.flush = flush;
  assign b1.flush = flush;
  assign b2.flush = flush;
  assign b3.flush = flush;
  assign b0.in_data = in_data;
  assign b1.in_data = in_data;
  assign b2.in_data = in_data;
  assign b3.in_data = in_data[7:0];
  assign b0.in_valid = in_valid;
  assign b1.in_valid = in_valid;
  assign b2.in_valid = in_valid;
  assign b3.in_valid = in_valid;
  assign b0.cnt_clr = cnt_clr;
  assign b1.cnt_clr = cnt_clr;
  assign b2.cnt_clr = cnt_clr;
  assign b3.cnt_clr = cnt_clr;

  pipe_stage_reg u0 (.clk(clk), .rst(rst), .bus(b0));

  pipe_stage_reg #(.FLUSH_KEEP(1'b1)) u1 (
    .clk(clk), .rst(rst), .bus(b1)
  );

  pipe_stage_reg #(.CNT_W(4)) u2 (
    .clk(clk), .rst(rst), .bus(b2)
  );

  pipe_stage_reg #(
    .DATA_W(8), .STAGE(0), .NOP_VAL(8'h00)
  ) u3 (
    .clk(clk), .rst(rst), .bus(b3)
  );

  logic [63:0] ad[4];
  logic        av[4];
  logic [15:0] ab[4];
  logic [15:0] ah[4];
  logic [15:0] af[4];

  assign ad[0] = b0.out_data;
  assign ad[1] = b1.out_data;
  assign ad[2] = b2.out_data;
  assign ad[3] = {56'b0, b3.out_data};
  assign av[0] = b0.out_valid;
  assign av[1] = b1.out_valid;
  assign av[2] = b2.out_valid;
  assign av[3] = b3.out_valid;
  assign ab[0] = b0.bubble_cnt;
  assign ab[1] = b1.bubble_cnt;
  assign ab[2] = {12'b0, b2.bubble_cnt};
  assign ab[3] = b3.bubble_cnt;
  assign ah[0] = b0.hold_cnt;
  assign ah[1] = b1.hold_cnt;
  assign ah[2] = {12'b0, b2.hold_cnt};
  assign ah[3] = b3.hold_cnt;
  assign af[0] = b0.flush_cnt;
  assign af[1] = b1.flush_cnt;
  assign af[2] = {12'b0, b2.flush_cnt};
  assign af[3] = b3.flush_cnt;

  // Reference model: per-variant parameters and architectural state.
  int          stg[4]  = '{2, 2, 2, 0};
  bit          keep[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  int          cmax[4] = '{65535, 65535, 15, 65535};
  logic [63:0] dmsk[4] = '{'1, '1, '1, 64'hFF};
  logic [63:0] md[4];
  logic        mv[4];
  int          mb[4];
  int          mh[4];
  int          mf[4];

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      md[i] = '0;
      mv[i] = 1'b0;
      mb[i] = 0;
      mh[i] = 0;
      mf[i] = 0;
    end
  endtask

  task automatic model_step();
    bit s, d;
    for (int i = 0; i < 4; i++) begin
      s = stall[stg[i]];
      d = stall[stg[i]+1];
      if (flush) begin
        mv[i] = 1'b0;
        if (!keep[i]) md[i] = '0;
        if (!cnt_clr) mf[i] = (mf[i] < cmax[i]) ? mf[i] + 1 : mf[i];
      end else if (s && !d) begin
        md[i] = '0;
        mv[i] = 1'b0;
        if (!cnt_clr) mb[i] = (mb[i] < cmax[i]) ? mb[i] + 1 : mb[i];
      end else if (s && d) begin
        if (!cnt_clr) mh[i] = (mh[i] < cmax[i]) ? mh[i] + 1 : mh[i];
      end else begin
        md[i] = in_data & dmsk[i];
        mv[i] = in_valid;
      end
      if (cnt_clr) begin
        mb[i] = 0;
        mh[i] = 0;
        mf[i] = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      assert (ad[i] === md[i]) else begin
        miscompares++;
        $error("FAIL %s u%0d data got %h exp %h", tag, i, ad[i], md[i]);
      end
      vectors++;
      assert (av[i] === mv[i]) else begin
        miscompares++;
        $error("FAIL %s u%0d valid got %b exp %b", tag, i, av[i], mv[i]);
      end
      vectors++;
      assert (int'(ab[i]) === mb[i]) else begin
        miscompares++;
        $error("FAIL %s u%0d bubble_cnt got %0d exp %0d", tag, i, ab[i], mb[i]);
      end
      vectors++;
      assert (int'(ah[i]) === mh[i]) else begin
        miscompares++;
        $error("FAIL %s u%0d hold_cnt got %0d exp %0d", tag, i, ah[i], mh[i]);
      end
      vectors++;
      assert (int'(af[i]) === mf[i]) else begin
        miscompares++;
        $error("FAIL %s u%0d flush_cnt got %0d exp %0d", tag, i, af[i], mf[i]);
      end
    end
  endtask

  task automatic cyc(input string tag, input logic [5:0] st, input logic fl,
                     input logic [63:0] dt, input logic vl, input logic clr);
    stall    = st;
    flush    = fl;
    in_data  = dt;
    in_valid = vl;
    cnt_clr  = clr;
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [6:0] t;
    int         k;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    cyc("advance", 6'b000000, 1'b0, 64'hDEAD_BEEF_0000_0001, 1'b1, 1'b0);
    repeat (3) cyc("hold", 6'b001111, 1'b0, 64'h1111, 1'b1, 1'b0);
    cyc("bubble", 6'b000111, 1'b0, 64'h2222, 1'b1, 1'b0);

    cyc("load", 6'b000000, 1'b0, 64'hCAFE_F00D_1234_5678, 1'b1, 1'b0);
    cyc("flush_hold", 6'b001111, 1'b1, 64'h3333, 1'b1, 1'b0);
    cyc("flush_bub", 6'b000111, 1'b1, 64'h4444, 1'b1, 1'b0);

    // Asynchronous reset between edges with valid content held.
    cyc("load2", 6'b000000, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #1 rst = 1'b0;

    cyc("load3", 6'b000000, 1'b0, 64'h5A5A_A5A5_0F0F_F0F0, 1'b1, 1'b0);
    repeat (20) cyc("sat_hold", 6'b001111, 1'b0, 64'h9, 1'b0, 1'b0);
    cyc("clr_hold", 6'b001111, 1'b0, 64'h9, 1'b0, 1'b1);
    cyc("post_clr", 6'b001111, 1'b0, 64'h9, 1'b0, 1'b0);

    cyc("s0_load", 6'b000000, 1'b0, 64'hFFFF_0000_FFFF_00A7, 1'b1, 1'b0);
    cyc("s0_hold", 6'b000011, 1'b0, 64'h77, 1'b1, 1'b0);
    cyc("s0_bub", 6'b000001, 1'b0, 64'h77, 1'b1, 1'b0);

    // Random legal (thermometer) stall vectors with sparse flush/clear.
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 6);
      t = (7'd1 << k) - 7'd1;
      cyc("random", t[5:0], ($urandom_range(0, 7) == 0),
          {$urandom, $urandom}, 1'($urandom_range(0, 1)),
          ($urandom_range(0, 31) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register, the successor to the fixed-field ID/EX latch.
- Carries an opaque payload bus plus a valid bit between any two adjacent pipeline stages.
- Uses the shared stall vector for its hold and bubble-insertion logic, and adds a flush input for branch/exception squash.
- Includes saturating per-stage performance counters (bubbles, holds, flushes) readable by the debug/CP0 side.

Parameters:
- DATA_W, 64, payload width in bits (packed aluop/alusel/operands/wd/wreg etc.).
- STALL_W, 6, width of the pipeline stall vector.
- STAGE, 2, index of this register's own stall bit; downstream bit is STAGE+1; legal range 0..STALL_W-2.
- NOP_VAL, {DATA_W{1'b0}}, payload value loaded on reset, bubble and flush.
- FLUSH_KEEP, 0, 0 = flush loads NOP_VAL; 1 = flush keeps payload, clears valid only (power saving).
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  STALL_W  pipeline stall vector from the stall controller (1 = Stop).
- flush  in  1  squash this stage's content next edge.
- in_data  in  DATA_W  payload from upstream stage.
- in_valid  in  1  upstream payload is a real instruction.
- cnt_clr  in  1  synchronous clear of all counters.
- out_data  out  DATA_W  registered payload to downstream stage.
- out_valid  out  1  registered valid.
- bubble_cnt  out  CNT_W  number of bubbles inserted.
- hold_cnt  out  CNT_W  number of cycles held.
- flush_cnt  out  CNT_W  number of flushes taken.

Behaviour:
- Reset (rst=1, asynchronous, takes effect immediately, independent of clk): out_data=NOP_VAL, out_valid=0, all counters=0. Deassertion is sampled on the next rising edge.
- Let s=stall[STAGE] and d=stall[STAGE+1]. On each rising edge the first true case below applies:
  1. flush=1: out_valid<=0; out_data<=NOP_VAL if FLUSH_KEEP=0, else out_data unchanged.
  2. s=1, d=0 (bubble): out_data<=NOP_VAL, out_valid<=0.
  3. s=1, d=1 (hold): out_data and out_valid unchanged.
  4. s=0 (advance): out_data<=in_data, out_valid<=in_valid.
- s=0 with d=1 is an illegal stall vector. The block advances in that case; the assertion is bench-side only.
- Flush wins over both hold and bubble in the same cycle.
- Latency is one cycle from in_* to out_* when advancing. There is no combinational path from input to output.
- Counters, evaluated on the same edge and cause exclusive:
  - flush_cnt increments when case 1 applies.
  - bubble_cnt increments when case 2 applies.
  - hold_cnt increments when case 3 applies.
- Counter arithmetic: each counter saturates at 2^CNT_W-1 and never wraps.
- cnt_clr=1 zeroes all counters on that edge, and an event in the same cycle is not counted. Priority order: rst, then cnt_clr, then increment. cnt_clr does not affect out_data or out_valid.
- Payload bits are never interpreted; NOP_VAL is the only encoding known to the block.
- Reset mid-hold or mid-bubble loses the held instruction; out_valid reads 0 immediately.

Test Plan:
- Reset: assert rst asynchronously between edges with out_valid=1 -> out_valid=0, out_data=NOP_VAL, counters 0 before the next edge.
- Advance: stall=6'b000000, in_data=64'hDEAD_BEEF_0000_0001, in_valid=1 -> next edge out_data=64'hDEAD_BEEF_0000_0001, out_valid=1, all counters unchanged.
- Hold then bubble (STAGE=2): stall=6'b001111 for 3 edges -> out_* frozen, hold_cnt=3. Then stall=6'b000111 for 1 edge -> out_data=NOP_VAL, out_valid=0, bubble_cnt=1.
- Flush priority: flush=1 with stall=6'b001111 and FLUSH_KEEP=0 -> out_data=NOP_VAL, out_valid=0, flush_cnt=1, hold_cnt unchanged. Repeat with FLUSH_KEEP=1 -> out_data retains its prior value, out_valid=0.
- Saturation and clear (CNT_W=4): 20 consecutive hold cycles -> hold_cnt=15. Then cnt_clr=1 together with a hold cycle -> hold_cnt=0 on that edge, and the next hold cycle gives hold_cnt=1.
- Parametrisation: instantiate STAGE=0, DATA_W=8 -> stall=6'b000001 bubbles, stall=6'b000011 holds, and widths are correct.
